// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with stall buffering and redirect squash.
// Optional FETCH_PERF_EN adds fetched/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_if_selpcsource,
  input  logic [1:0]  id_if_selpctype,
  input  logic [31:0] id_if_pcimd2ext,
  input  logic [31:0] id_if_pcindex,
  input  logic [31:0] id_if_rega,
  input  logic        iss_stall,
  output logic        if_mem_req,
  output logic [31:0] if_mem_addr,
  input  logic        mem_if_ready,
  input  logic [31:0] mem_if_data,
  output logic [31:0] if_id_instruc,
  output logic [31:0] if_id_nextpc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] if_perf_fetched,
  output logic [31:0] if_perf_bubbles
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;
  state_t state;
  logic [31:0] pc, hold_buf, hold_pc4, redirect_pc, pc4, target;
  logic redir, ld_valid, ld_nop;
  assign pc4 = pc + 32'd4;
  assign redir = id_if_selpcsource & ~iss_stall;
  assign target = id_if_selpctype == 2'b01 ? id_if_pcindex :
                  id_if_selpctype == 2'b10 ? id_if_rega : id_if_pcimd2ext;
  assign if_mem_req = reset & (state != HOLD);
  assign if_mem_addr = pc;
  assign ld_valid = ~iss_stall & ~redir &
                    ((state == FETCH & mem_if_ready) | state == HOLD);
  assign ld_nop = ~iss_stall & ((state == FETCH & (redir | ~mem_if_ready)) |
                                (state == HOLD & redir) | state == SQUASH);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      hold_buf <= 32'h0;
      hold_pc4 <= 32'h0;
      redirect_pc <= 32'h0;
      if_id_instruc <= NOP_WORD;
      if_id_nextpc <= 32'h0;
    end else begin
      if (ld_valid) begin
        if_id_instruc <= state == HOLD ? hold_buf : mem_if_data;
        if_id_nextpc <= state == HOLD ? hold_pc4 : pc4;
      end else if (ld_nop) begin
        if_id_instruc <= NOP_WORD;
        if_id_nextpc <= 32'h0;
      end
      case (state)
        FETCH:
          if (mem_if_ready) begin
            if (redir) pc <= target;
            else begin
              pc <= pc4;
              if (iss_stall) begin
                hold_buf <= mem_if_data;
                hold_pc4 <= pc4;
                state <= HOLD;
              end
            end
          end else if (redir) begin
            redirect_pc <= target;
            state <= SQUASH;
          end
        HOLD:
          if (!iss_stall) begin
            state <= FETCH;
            if (redir) pc <= target;
          end
        SQUASH:
          if (mem_if_ready) begin
            pc <= redirect_pc;
            state <= FETCH;
          end
        default: state <= FETCH;
      endcase
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_perf_fetched <= 32'h0;
      if_perf_bubbles <= 32'h0;
    end else begin
      if_perf_fetched <= if_perf_fetched + {31'h0, ld_valid};
      if_perf_bubbles <= if_perf_bubbles + {31'h0, ld_nop};
    end
  end
`endif
endmodule
